// File: rtl/bitstream_pkg.sv
// Shared definitions for the bitstream window block.
//   WIN_W        : width of the left-aligned bit window
//   OUT_W        : bits presented to the syntax parser (window top)
//   REFILL_LIMIT : bits held plus bits in flight at or below which a pop is issued
//   CNT_W        : width of the valid-bit counter
//   EPB_BYTE     : emulation-prevention byte removed after two zero bytes
//   START_BYTE   : final byte of a 00 00 01 start code
// classify_byte() sorts an incoming byte by the zero-run rules.
package bitstream_pkg;

  localparam int WIN_W        = 64;
  localparam int OUT_W        = 32;
  localparam int REFILL_LIMIT = 48;
  localparam int CNT_W        = 7;

  localparam logic [7:0] EPB_BYTE   = 8'h03;
  localparam logic [7:0] START_BYTE = 8'h01;

  typedef enum logic [1:0] {
    BYTE_ZERO  = 2'd0,  // 0x00, extends the zero run
    BYTE_PASS  = 2'd1,  // ordinary byte, clears the zero run
    BYTE_DROP  = 2'd2,  // emulation-prevention byte, removed
    BYTE_START = 2'd3   // closes a 00 00 01 start code
  } byte_class_e;

  function automatic byte_class_e classify_byte(input logic [7:0] b,
                                                input logic [1:0] zero_run,
                                                input logic       epb_en);
    byte_class_e c;
    if (b == 8'h00)                                        c = BYTE_ZERO;
    else if (zero_run == 2'd2 && b == EPB_BYTE && epb_en)  c = BYTE_DROP;
    else if (zero_run == 2'd2 && b == START_BYTE)          c = BYTE_START;
    else                                                   c = BYTE_PASS;
    return c;
  endfunction

endpackage

// File: rtl/bitstream_window_epb_filter.sv
// epb_filter: one register stage between the FIFO data and the bit window.
// Tracks runs of 0x00, removes emulation-prevention bytes and flags start codes.
// Ports:
//   clk_i, rst_i     : clock, asynchronous active-high reset
//   epb_en_i         : 1 = remove 00 00 03 escape bytes
//   byte_i           : FIFO data
//   byte_valid_i     : byte_i carries a popped byte this cycle
//   byte_o           : registered byte
//   byte_valid_o     : byte_o is to be inserted into the window
//   start_o          : byte_o closes a 00 00 01 start code (one-cycle pulse)
//   occupied_o       : the stage holds a byte, kept or dropped
module epb_filter
  import bitstream_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       epb_en_i,
  input  logic [7:0] byte_i,
  input  logic       byte_valid_i,
  output logic [7:0] byte_o,
  output logic       byte_valid_o,
  output logic       start_o,
  output logic       occupied_o
);

  logic [7:0]  byte_q, byte_d;
  logic        valid_q, valid_d;
  logic        start_q, start_d;
  logic        occ_q, occ_d;
  logic [1:0]  zero_run_q, zero_run_d;
  byte_class_e cls;

  always_comb begin
    cls        = classify_byte(byte_i, zero_run_q, epb_en_i);
    byte_d     = byte_q;
    valid_d    = 1'b0;
    start_d    = 1'b0;
    occ_d      = byte_valid_i;
    zero_run_d = zero_run_q;
    if (byte_valid_i) begin
      byte_d  = byte_i;
      valid_d = (cls != BYTE_DROP);
      start_d = (cls == BYTE_START);
      // Zero run saturates at two; every nonzero byte (kept or dropped) ends it.
      if (cls == BYTE_ZERO) begin
        zero_run_d = (zero_run_q == 2'd2) ? 2'd2 : zero_run_q + 2'd1;
      end else begin
        zero_run_d = 2'd0;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      byte_q     <= 8'h00;
      valid_q    <= 1'b0;
      start_q    <= 1'b0;
      occ_q      <= 1'b0;
      zero_run_q <= 2'd0;
    end else begin
      byte_q     <= byte_d;
      valid_q    <= valid_d;
      start_q    <= start_d;
      occ_q      <= occ_d;
      zero_run_q <= zero_run_d;
    end
  end

  assign byte_o       = byte_q;
  assign byte_valid_o = valid_q;
  assign start_o      = start_q;
  assign occupied_o   = occ_q;

endmodule

// File: rtl/bitstream_window.sv
// bitstream_window: consumer end of the byte-stream FIFO. Pops bytes, filters
// them through epb_filter and keeps a 64-bit left-aligned bit window whose top
// 32 bits feed the syntax parser.
// Ports:
//   clk, rst          : clock, asynchronous active-high reset
//   EPB_EN            : 1 = strip emulation-prevention bytes (quasi-static)
//   stream_in         : FIFO data, valid the cycle after a read pulse
//   stream_in_valid   : FIFO holds at least two bytes, or is full
//   stream_empty      : FIFO empty
//   stream_over       : source has reached end of file (level)
//   read              : FIFO pop pulse
//   bits_out          : window[63:32], MSB is the next bit
//   bits_valid        : bits_out is meaningful
//   consume/consume_len : drop consume_len (0..32) bits this cycle
//   align             : drop bits up to the next byte boundary (beats consume)
//   byte_aligned      : bit position is a multiple of 8
//   start_code_found  : pulse when a 00 00 01 byte leaves the filter
//   eos               : stream exhausted and window empty, sticky until rst
//
// FIFO handshake: read is a pop request the FIFO always honours; the popped
// byte appears on stream_in exactly one cycle later, with no back-pressure.
// A pop is only requested when the FIFO reports enough data (two bytes, or
// any byte once the source is over) and when the window has room for every
// byte already in flight, so a returned byte can never be refused.
module bitstream_window
  import bitstream_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             EPB_EN,
  input  logic [7:0]       stream_in,
  input  logic             stream_in_valid,
  input  logic             stream_empty,
  input  logic             stream_over,
  output logic             read,
  output logic [OUT_W-1:0] bits_out,
  output logic             bits_valid,
  input  logic             consume,
  input  logic [5:0]       consume_len,
  input  logic             align,
  output logic             byte_aligned,
  output logic             start_code_found,
  output logic             eos
);

  localparam logic [7:0]       LIMIT    = 8'(REFILL_LIMIT);
  localparam logic [CNT_W-1:0] OUT_BITS = CNT_W'(OUT_W);

  logic [WIN_W-1:0] window_q, window_d, shifted;
  logic [CNT_W-1:0] count_q, count_d, remaining;
  logic [1:0]       inflight_q, inflight_d;
  logic             rd_q;
  logic             eos_q, eos_d;
  logic [5:0]       shift;
  logic [7:0]       committed;
  logic             src_ok, drained;
  logic [7:0]       filt_byte;
  logic             filt_valid, filt_start, filt_occ;

  epb_filter u_filter (
    .clk_i        (clk),
    .rst_i        (rst),
    .epb_en_i     (EPB_EN),
    .byte_i       (stream_in),
    .byte_valid_i (rd_q),
    .byte_o       (filt_byte),
    .byte_valid_o (filt_valid),
    .start_o      (filt_start),
    .occupied_o   (filt_occ)
  );

  // inflight covers a byte from its pop until it leaves the filter, so the
  // FIFO data stage and the filter stage are both accounted for (max 2).
  assign committed = {1'b0, count_q} + {3'd0, inflight_q, 3'd0};
  assign src_ok    = stream_over ? !stream_empty : stream_in_valid;
  assign read      = !rst && src_ok && (committed <= LIMIT);

  assign drained    = stream_over && stream_empty && (inflight_q == 2'd0) && !filt_occ;
  assign bits_valid = (count_q >= OUT_BITS) || (drained && count_q != '0);
  assign eos_d      = eos_q || (drained && count_q == '0);
  assign eos        = !rst && eos_d;

  assign bits_out         = window_q[WIN_W-1 -: OUT_W];
  assign byte_aligned     = (count_q[2:0] == 3'd0);
  assign start_code_found = filt_start;

  // Shift amount: align first, then a legal consume. A consume larger than the
  // bits held (only possible in the drained tail) is clamped to the window.
  always_comb begin
    shift = 6'd0;
    if (align) begin
      shift = {3'd0, count_q[2:0]};
    end else if (consume && bits_valid) begin
      if ({1'b0, consume_len} > count_q) shift = count_q[5:0];
      else                               shift = consume_len;
    end
  end

  // Shift before insert: the new byte lands directly below the bits that
  // survive this cycle's shift. Bits below count are always zero.
  always_comb begin
    shifted   = window_q << shift;
    remaining = count_q - {1'b0, shift};
    window_d  = shifted;
    count_d   = remaining;
    if (filt_valid) begin
      window_d = shifted | ({filt_byte, {(WIN_W-8){1'b0}}} >> remaining);
      count_d  = remaining + 7'd8;
    end
  end

  always_comb begin
    inflight_d = inflight_q;
    if (read && !filt_occ)      inflight_d = inflight_q + 2'd1;
    else if (!read && filt_occ) inflight_d = inflight_q - 2'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      window_q   <= '0;
      count_q    <= '0;
      inflight_q <= 2'd0;
      rd_q       <= 1'b0;
      eos_q      <= 1'b0;
    end else begin
      window_q   <= window_d;
      count_q    <= count_d;
      inflight_q <= inflight_d;
      rd_q       <= read;
      eos_q      <= eos_d;
    end
  end

endmodule

// File: tb/tb_bitstream_window.sv
// Testbench for bitstream_window. The bench plays the FIFO (a byte queue with
// registered read data) and keeps the expected filtered bitstream as a queue
// of bits; bits_out is compared against the head of that queue.
module tb_bitstream_window;

  localparam int FIFO_DEPTH = 16;

  // ---------------- clock / reset / DUT ----------------
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        epb_en = 1'b1;
  logic [7:0]  stream_in = 8'h00;
  logic        stream_in_valid = 1'b0;
  logic        stream_empty = 1'b1;
  logic        stream_over = 1'b0;
  logic        read;
  logic [31:0] bits_out;
  logic        bits_valid;
  logic        consume = 1'b0;
  logic [5:0]  consume_len = 6'd0;
  logic        align = 1'b0;
  logic        byte_aligned;
  logic        start_code_found;
  logic        eos;

  always #5 clk = ~clk;

  bitstream_window dut (
    .clk              (clk),
    .rst              (rst),
    .EPB_EN           (epb_en),
    .stream_in        (stream_in),
    .stream_in_valid  (stream_in_valid),
    .stream_empty     (stream_empty),
    .stream_over      (stream_over),
    .read             (read),
    .bits_out         (bits_out),
    .bits_valid       (bits_valid),
    .consume          (consume),
    .consume_len      (consume_len),
    .align            (align),
    .byte_aligned     (byte_aligned),
    .start_code_found (start_code_found),
    .eos              (eos)
  );

  always @(negedge clk) begin
    if (consume) assert (consume_len <= 6'd32) else $error("illegal consume_len %0d", consume_len);
  end

  // ---------------- model state ----------------
  logic [7:0] src_q[$];    // bytes not yet in the FIFO
  logic [7:0] fifo_q[$];   // FIFO contents
  logic [0:0] exp_q[$];    // expected bitstream after filtering, not yet consumed
  int ref_zero_run;
  int start_exp, start_seen;
  int pos_mod8;
  int checks = 0;
  int errors = 0;
  bit fast_push = 1'b1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  // Append a source byte and derive the bits the parser should see from it.
  task automatic queue_byte(input logic [7:0] b);
    bit keep;
    keep = 1'b1;
    src_q.push_back(b);
    if (b == 8'h00) begin
      ref_zero_run = (ref_zero_run < 2) ? ref_zero_run + 1 : 2;
    end else begin
      if (ref_zero_run == 2 && b == 8'h03 && epb_en) keep = 1'b0;
      else if (ref_zero_run == 2 && b == 8'h01) start_exp++;
      ref_zero_run = 0;
    end
    if (keep) for (int i = 7; i >= 0; i--) exp_q.push_back(b[i]);
  endtask

  task automatic update_fifo();
    if (src_q.size() > 0 && fifo_q.size() < FIFO_DEPTH && (fast_push || $urandom_range(0, 2) == 0))
      fifo_q.push_back(src_q.pop_front());
    stream_in_valid = (fifo_q.size() >= 2) || (fifo_q.size() == FIFO_DEPTH);
    stream_empty    = (fifo_q.size() == 0);
  endtask

  task automatic preload();
    while (src_q.size() > 0 && fifo_q.size() < FIFO_DEPTH - 1) fifo_q.push_back(src_q.pop_front());
    update_fifo();
  endtask

  function automatic logic [31:0] exp_top32();
    logic [31:0] v;
    v = '0;
    for (int i = 0; i < 32; i++) if (i < exp_q.size()) v[31-i] = exp_q[i];
    return v;
  endfunction

  // ---------------- driver: one clock cycle ----------------
  // Entered and left 1 time unit after a rising edge.
  task automatic step(input logic c, input logic [5:0] len, input logic al);
    logic rd, vld;
    int drop;
    consume = c; consume_len = len; align = al;
    #4;
    rd  = read;
    vld = bits_valid;
    if (vld) check_eq("bits_out", bits_out, exp_top32());
    check_eq("byte_aligned", 32'(byte_aligned), 32'(pos_mod8 == 0));
    if (exp_q.size() == 0) check_eq("valid_when_empty", 32'(vld), 32'd0);
    if (!stream_over) check_eq("eos_early", 32'(eos), 32'd0);
    if (start_code_found) start_seen++;
    drop = 0;
    if (al) drop = (8 - pos_mod8) % 8;
    else if (c && vld) drop = int'(len);
    if (drop > exp_q.size()) drop = exp_q.size();
    repeat (drop) void'(exp_q.pop_front());
    pos_mod8 = (pos_mod8 + drop) % 8;
    @(posedge clk);
    #1;
    if (rd) begin
      check_eq("read_on_empty", 32'(fifo_q.size() != 0), 32'd1);
      if (fifo_q.size() != 0) stream_in = fifo_q.pop_front();
    end
    update_fifo();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    consume = 1'b0; align = 1'b0; stream_over = 1'b0;
    src_q.delete(); fifo_q.delete(); exp_q.delete();
    ref_zero_run = 0; pos_mod8 = 0; start_seen = 0; start_exp = 0;
    stream_in = 8'h00;
    update_fifo();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic wait_valid(input string tag);
    int n;
    n = 0;
    while (!bits_valid && n < 100) begin
      step(1'b0, 6'd0, 1'b0);
      n++;
    end
    check_eq(tag, 32'(bits_valid), 32'd1);
  endtask

  // Random consume/align until every source byte has been read and consumed.
  task automatic run_to_eos(input string tag, input int max_cycles);
    int n, want;
    n = 0;
    while (n < max_cycles && !(src_q.size() == 0 && fifo_q.size() == 0 && exp_q.size() == 0)) begin
      if (src_q.size() == 0) stream_over = 1'b1;
      want = $urandom_range(0, 32);
      if (want > exp_q.size()) want = exp_q.size();
      step($urandom_range(0, 3) != 0, 6'(want), $urandom_range(0, 9) == 0);
      n++;
    end
    check_eq({tag, "_drain_done"}, 32'(exp_q.size()), 32'd0);
    repeat (3) step(1'b0, 6'd0, 1'b0);
    check_eq({tag, "_eos"}, 32'(eos), 32'd1);
    check_eq({tag, "_valid_at_eos"}, 32'(bits_valid), 32'd0);
    check_eq({tag, "_starts"}, 32'(start_seen), 32'(start_exp));
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_read"}, 32'(read), 32'd0);
    check_eq({tag, "_bits_valid"}, 32'(bits_valid), 32'd0);
    check_eq({tag, "_bits_out"}, bits_out, 32'd0);
    check_eq({tag, "_byte_aligned"}, 32'(byte_aligned), 32'd1);
    check_eq({tag, "_start"}, 32'(start_code_found), 32'd0);
    check_eq({tag, "_eos"}, 32'(eos), 32'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [7:0] head [6];
    logic [7:0] algn [8];
    logic [7:0] tail [5];
    int nbytes, sel;
    head = '{8'hAA, 8'h55, 8'hCC, 8'h33, 8'hFF, 8'h00};
    algn = '{8'hC3, 8'h5A, 8'h96, 8'hE1, 8'h7B, 8'h2D, 8'hF0, 8'h4E};
    tail = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h9A};
    ref_zero_run = 0; start_exp = 0; start_seen = 0; pos_mod8 = 0;

    // Reset values, with a stream already waiting in the FIFO.
    for (int i = 0; i < 4; i++) fifo_q.push_back(8'h11);
    update_fifo();
    @(posedge clk);
    #1;
    check_reset_outputs("reset");
    do_reset();

    // Sustained 8 bits per cycle.
    epb_en = 1'b1;
    fast_push = 1'b1;
    foreach (head[i]) queue_byte(head[i]);
    for (int i = 0; i < 42; i++) queue_byte(8'($urandom_range(1, 255)));
    preload();
    wait_valid("t1_fill");
    check_eq("t1_first", bits_out, 32'hAA55CC33);
    step(1'b1, 6'd8, 1'b0);
    check_eq("t1_second", bits_out, 32'h55CC33FF);
    for (int i = 0; i < 16; i++) begin
      check_eq("t1_no_stall", 32'(bits_valid), 32'd1);
      step(1'b1, 6'd8, 1'b0);
    end
    run_to_eos("t1", 400);

    // Escape removal on: 00 00 03 01 -> 00 00 01.
    do_reset();
    epb_en = 1'b1;
    queue_byte(8'h00); queue_byte(8'h00); queue_byte(8'h03); queue_byte(8'h01);
    preload();
    stream_over = 1'b1;
    wait_valid("t2_valid");
    check_eq("t2_window", bits_out, 32'h00000100);
    run_to_eos("t2", 100);

    // Escape removal off: every byte passes.
    do_reset();
    epb_en = 1'b0;
    queue_byte(8'h00); queue_byte(8'h00); queue_byte(8'h03); queue_byte(8'h01);
    preload();
    stream_over = 1'b1;
    wait_valid("t3_valid");
    check_eq("t3_window", bits_out, 32'h00000301);
    run_to_eos("t3", 100);

    // Consume 3 then align; align beats a simultaneous consume.
    do_reset();
    epb_en = 1'b1;
    foreach (algn[i]) queue_byte(algn[i]);
    preload();
    wait_valid("t4_valid");
    step(1'b1, 6'd3, 1'b0);
    check_eq("t4_unaligned", 32'(byte_aligned), 32'd0);
    step(1'b0, 6'd0, 1'b1);
    check_eq("t4_aligned", 32'(byte_aligned), 32'd1);
    check_eq("t4_next_byte", 32'(bits_out[31:24]), 32'h5A);
    step(1'b1, 6'd5, 1'b1);
    check_eq("t4_align_priority", 32'(bits_out[31:24]), 32'h5A);
    run_to_eos("t4", 200);

    // Five-byte stream tail: padded output, then end of stream.
    do_reset();
    foreach (tail[i]) queue_byte(tail[i]);
    preload();
    stream_over = 1'b1;
    wait_valid("t5_valid");
    check_eq("t5_first", bits_out, 32'h12345678);
    step(1'b1, 6'd32, 1'b0);
    wait_valid("t5_tail_valid");
    check_eq("t5_tail", bits_out, 32'h9A000000);
    step(1'b1, 6'd8, 1'b0);
    check_eq("t5_eos", 32'(eos), 32'd1);
    check_eq("t5_valid_off", 32'(bits_valid), 32'd0);

    // Reset during a fill with two bytes in flight, then a clean refill.
    do_reset();
    for (int i = 0; i < 20; i++) queue_byte(8'($urandom_range(1, 255)));
    preload();
    step(1'b0, 6'd0, 1'b0);
    step(1'b0, 6'd0, 1'b0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check_reset_outputs("midrst");
    do_reset();
    for (int i = 0; i < 12; i++) queue_byte(8'($urandom_range(1, 255)));
    preload();
    wait_valid("t6_refill");
    run_to_eos("t6", 200);

    // Randomised rounds with bytes biased toward zero runs, escapes and start codes.
    for (int r = 0; r < 6; r++) begin
      do_reset();
      epb_en = 1'($urandom_range(0, 1));
      fast_push = 1'($urandom_range(0, 1));
      nbytes = $urandom_range(30, 60);
      for (int i = 0; i < nbytes; i++) begin
        sel = $urandom_range(0, 5);
        case (sel)
          0, 1:    queue_byte(8'h00);
          2:       queue_byte(8'h03);
          3:       queue_byte(8'h01);
          default: queue_byte(8'($urandom_range(0, 255)));
        endcase
      end
      run_to_eos("rand", 2000);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/bitstream_window.md
# bitstream_window

Consumer end of the byte-stream FIFO interface. Pops bytes from the bitstream FIFO, strips H.264 emulation-prevention bytes, flags start codes, and keeps a 64-bit left-aligned bit window. The syntax parser sees the top 32 bits and consumes 0–32 bits per cycle. Sits between the SD/FIFO front end and the slice/NAL parsers.

## Interface
- EPB_EN, 1: 1 = remove emulation-prevention 0x03; 0 = pass every byte through.
- clk  in  1  single clock; all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- stream_in  in  8  FIFO q, registered; valid the cycle after the `read` pulse.
- stream_in_valid  in  1  FIFO holds ≥2 bytes, or is full.
- stream_empty  in  1  FIFO empty flag.
- stream_over  in  1  source reached end of file (level).
- read  out  1  FIFO pop pulse, one byte per cycle.
- bits_out  out  32  window[63:32], MSB = next bit.
- bits_valid  out  1  bits_out is meaningful (see Operation).
- consume  in  1  drop consume_len bits this cycle.
- consume_len  in  6  0..32; values >32 are illegal (bench asserts on them).
- align  in  1  drop bits up to the next byte boundary.
- byte_aligned  out  1  bit position is a multiple of 8.
- start_code_found  out  1  one-cycle pulse when 00 00 01 enters the window.
- eos  out  1  stream exhausted and window empty (sticky until rst).

## Operation
- State:
  - window[63:0], left-aligned;
  - count[6:0], valid bits;
  - inflight[1:0], reads not yet returned;
  - filter register plus zero_run[1:0].
- Read issue:
  - Normal: `read` = stream_in_valid && count + 8·inflight ≤ 48.
  - Drain mode (stream_over high): the condition uses !stream_empty in place of stream_in_valid.
  - count never exceeds 56.
- epb_filter, one register stage:
  - zero_run counts consecutive 0x00 bytes, saturating at 2.
  - Byte 0x03 with zero_run==2 and EPB_EN: dropped, zero_run←0.
  - Byte 0x01 with zero_run==2: byte passes, start_code_found pulses, zero_run←0.
  - Any other nonzero byte: passes, zero_run←0.
- Window update, per cycle, in order:
  1. Shift left by s.
     - s = consume_len if consume && bits_valid.
     - s = count mod 8 if align. align has priority; consume is ignored that cycle.
     - s = 0 otherwise.
  2. Insert the filtered byte, if present, at bits [63−(count−s) −: 8].
  3. count ← count − s + 8·insert.
- bits_valid = count ≥ 32, or (drained && count > 0). Missing low bits read as 0.
- drained = stream_over && stream_empty && inflight==0 && filter empty.
- eos = drained && count==0.
- consume while !bits_valid is ignored.
- byte_aligned = (count mod 8 == 0).

## Timing
- Reset values:
  - read=0, bits_valid=0, start_code_found=0, eos=0;
  - window=0, count=0, inflight=0, zero_run=0, filter empty;
  - bits_out=0, byte_aligned=1.
- Read-to-window latency: read at t → byte in filter at t+2 → window/count updated at t+3.
- Consume-to-output latency: consume at t → shifted bits_out and bits_valid visible at t+1.
- Simultaneous consume + insert in one cycle is legal; the shift is applied before the insert.
- Reset mid-stream discards the window and filter state. FIFO contents are not this block's concern.
- Steady-state throughput: 8 bits/cycle sustained input.

## Structure
- Shared package `bitstream_pkg`:
  - WIN_W=64, OUT_W=32, REFILL_LIMIT=48;
  - EPB_BYTE=8'h03, START_BYTE=8'h01.
- Sub-module `epb_filter`: byte register, zero_run, drop/start-code decision; outputs byte + byte_valid + start pulse.
- Top holds the read issuer, inflight counter, window/count, and status logic.

## Test plan
- Bytes AA 55 CC 33 FF 00 …, consume 8 every cycle → bits_out sequence AA55CC33, 55CC33FF, …; no stall after the first fill.
- Bytes 00 00 03 01 with EPB_EN=1 → window holds 0x000001; start_code_found pulses once; 0x03 never seen.
- Same bytes with EPB_EN=0 → window holds 0x00000301; no start pulse.
- consume_len=3, then align → count drops to the next multiple of 8; byte_aligned=1; bits_out = next whole byte at [31:24].
- Stream of 5 bytes (0x12 34 56 78 9A) then stream_over, consume 32 →
  - bits_out=0x12345678, then 0x9A000000 with bits_valid=1;
  - after consume 8, eos=1 and bits_valid=0.
- Assert rst during a fill with inflight=2 → all outputs at reset values next cycle; a refill after release restarts cleanly.
